mem_stage: RTL

- Memory-access stage directly downstream of the execute stage.
- Consumes the registered ALU result and the one-cycle kick-up pulse from execute. Performs loads and stores over a simple request/ready data-memory port; ALU-only instructions pass through.
- Emits a registered result plus a one-cycle kick-up pulse to the write-back stage, keeping the same pulse-chained sequencing used across the single-issue datapath.

---
 rtl/mem_stage_if.sv | 46 ++++
 rtl/mem_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Data-memory request/ready port used by the memory-access stage.
//
// Signals:
//   dmem_req    stage -> memory  access request, held until ready or abort
//   dmem_we     stage -> memory  1 = write, 0 = read (valid with dmem_req)
//   dmem_addr   stage -> memory  word-aligned byte address
//   dmem_wdata  stage -> memory  store data replicated into byte lanes
//   dmem_wstrb  stage -> memory  byte-lane enables (0000 for reads)
//   dmem_rdata  memory -> stage  read data, valid with dmem_ready
//   dmem_ready  memory -> stage  access completes this cycle
//
// Modports:
//   master  the memory stage (issues requests)
//   slave   the data memory (answers requests)
// -----------------------------------------------------------------------------
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_rdata,
        output dmem_ready
    );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the single-issue datapath. Takes the registered ALU
// result and the one-cycle kick pulse from execute, performs loads/stores over
// a request/ready data-memory port, and hands a registered result plus a
// one-cycle kick pulse to write-back. ALU-only instructions pass straight
// through with one cycle of latency.
//
// Parameters:
//   WAIT_TIMEOUT  cycles to wait for dmem_ready before aborting (1..255)
//
// Ports:
//   clk                     system clock, rising edge
//   reset                   asynchronous reset, active low
//   ALU_result              load/store address, or pass-through value
//   reg_read_data_2         store data
//   Controller_memread      instruction is a load
//   Controller_memwrite     instruction is a store (wins over memread)
//   Controller_memsize      0 byte, 1 half, 2 word, 3 treated as word
//   Controller_memunsigned  1 zero-extends loads, 0 sign-extends
//   ALU_kick_up             inputs valid this cycle
//   dmem                    data-memory port (mem_stage_if.master)
//   MEM_result              registered result for write-back
//   MEM_error               sticky: last access timed out (or trapped)
//   MEM_kick_up             one-cycle pulse: MEM_result valid
//
// Build option:
//   MEM_MISALIGN_TRAP_EN    when defined, misaligned half/word accesses are
//                           not issued; they complete with MEM_error=1 and a
//                           zero result. Otherwise lanes come from the low
//                           address bits and no fault is raised.
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        reg_read_data_2,
    input  logic               Controller_memread,
    input  logic               Controller_memwrite,
    input  logic [1:0]         Controller_memsize,
    input  logic               Controller_memunsigned,
    input  logic               ALU_kick_up,
    mem_stage_if.master        dmem,
    output logic [31:0]        MEM_result,
    output logic               MEM_error,
    output logic               MEM_kick_up
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last counter value before the access is abandoned.
    localparam logic [7:0] LP_CNT_LAST = 8'(WAIT_TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // Lane helpers
    // -------------------------------------------------------------------------
    function automatic logic [3:0] f_wstrb(input logic [1:0] size,
                                           input logic [1:0] a);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << a;
            2'd1:    strb = a[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0]  size,
                                            input logic [31:0] d);
        logic [31:0] data;
        case (size)
            2'd0:    data = {4{d[7:0]}};
            2'd1:    data = {2{d[15:0]}};
            default: data = d;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] rdata,
                                           input logic [1:0]  size,
                                           input logic [1:0]  a,
                                           input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (a)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'd0:    res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_uns;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_result;
    logic        r_error;
    logic        r_kick;

    state_t      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [31:0] w_result_nxt;
    logic        w_error_nxt;
    logic        w_kick_nxt;
    logic        w_latch;
    logic        w_is_mem;
    logic        w_is_store;
    logic        w_req;

    assign w_is_mem   = Controller_memread | Controller_memwrite;
    // A load+store encoding is handled as a store.
    assign w_is_store = Controller_memwrite;

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned;
    always_comb begin
        w_misaligned = 1'b0;
        case (Controller_memsize)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = ALU_result[0];
            default: w_misaligned = |ALU_result[1:0];
        endcase
    end
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and result logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_error_nxt  = r_error;
        w_kick_nxt   = 1'b0;
        w_latch      = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (ALU_kick_up) begin
                    if (!w_is_mem) begin
                        w_result_nxt = ALU_result;
                        w_kick_nxt   = 1'b1;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (w_misaligned) begin
                        w_result_nxt = '0;
                        w_error_nxt  = 1'b1;
                        w_state_nxt  = DONE;
                    end
`endif
                    else begin
                        w_latch     = 1'b1;
                        w_state_nxt = ACCESS;
                    end
                end
            end

            ACCESS: begin
                if (dmem.dmem_ready) begin
                    // Stores report their address so write-back sees a value.
                    w_result_nxt = r_we ? r_addr
                                        : f_load(dmem.dmem_rdata, r_size,
                                                 r_addr[1:0], r_uns);
                    w_error_nxt  = 1'b0;
                    w_state_nxt  = DONE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_result_nxt = '0;
                    w_error_nxt  = 1'b1;
                    w_state_nxt  = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            DONE: begin
                w_kick_nxt  = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_size   <= '0;
            r_uns    <= 1'b0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_kick   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_error  <= w_error_nxt;
            r_kick   <= w_kick_nxt;
            if (w_latch) begin
                r_addr  <= ALU_result;
                r_size  <= Controller_memsize;
                r_uns   <= Controller_memunsigned;
                r_we    <= w_is_store;
                r_wdata <= f_wdata(Controller_memsize, reg_read_data_2);
                r_wstrb <= w_is_store ? f_wstrb(Controller_memsize,
                                                ALU_result[1:0])
                                      : 4'b0000;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Request follows the state register directly so an asynchronous reset
    // removes it immediately; the rest of the bus is quiet when idle.
    assign w_req           = (r_state == ACCESS);
    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = w_req & r_we;
    assign dmem.dmem_addr  = w_req ? {r_addr[31:2], 2'b00} : '0;
    assign dmem.dmem_wdata = w_req ? r_wdata : '0;
    assign dmem.dmem_wstrb = w_req ? r_wstrb : '0;

    assign MEM_result  = r_result;
    assign MEM_error   = r_error;
    assign MEM_kick_up = r_kick;

endmodule
